// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Data memory for the MEM stage of a simple in-order pipeline. A request
// (MemRead and/or MemWrite) is accepted in IDLE, the pipeline is frozen via
// mem_stall while a fixed LATENCY elapses, and the access completes on the
// edge that enters DONE, where resp_valid pulses for exactly one cycle.
// Two fixed byte addresses are mirrored combinationally on out1/out2.
//
// Parameters
//   DEPTH      number of 32-bit words (power of two)
//   LATENCY    cycles from request acceptance to resp_valid (1..15)
//   OUT1_ADDR  byte address mirrored on out1
//   OUT2_ADDR  byte address mirrored on out2
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (clears state and the array)
//   MemRead     read request
//   MemWrite    write request (wins over MemRead when both are set)
//   address     byte address (ALU result)
//   write_data  store data
//   read_data   registered load data, held outside DONE
//   mem_stall   combinational pipeline freeze request
//   resp_valid  one-cycle completion pulse (high exactly in DONE)
//   addr_err    misaligned / out-of-range flag, valid with resp_valid
//   out1, out2  array words at OUT1_ADDR / OUT2_ADDR
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 3,
    parameter logic [31:0] OUT1_ADDR = 32'd512,
    parameter logic [31:0] OUT2_ADDR = 32'd516
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_stall,
    output logic        resp_valid,
    output logic        addr_err,
    output logic [31:0] out1,
    output logic [31:0] out2
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] BYTE_SIZE = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

    // Mirror taps resolved at elaboration; an out-of-range tap reads as 0.
    localparam bit          OUT1_OK  = (OUT1_ADDR < BYTE_SIZE);
    localparam bit          OUT2_OK  = (OUT2_ADDR < BYTE_SIZE);
    localparam logic [AW-1:0] OUT1_IDX = OUT1_ADDR[AW+1:2];
    localparam logic [AW-1:0] OUT2_IDX = OUT2_ADDR[AW+1:2];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    // Latched request, used for the whole access so the block never depends
    // on the pipeline keeping its inputs stable beyond acceptance.
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_rd;
    logic        lat_wr;

    logic        req;
    logic        commit;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_rd;
    logic        acc_wr;
    logic        acc_oob;
    logic        acc_mis;
    logic [AW-1:0] acc_idx;

    assign req = MemRead | MemWrite;

    // The access commits on the edge that enters DONE. With LATENCY==1 that
    // is the acceptance edge itself, so the live inputs are the only copy
    // available; otherwise the latched request is used.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        commit    = 1'b0;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_rd    = lat_rd;
        acc_wr    = lat_wr;
        unique case (state)
            IDLE: begin
                acc_addr  = address;
                acc_wdata = write_data;
                acc_rd    = MemRead;
                acc_wr    = MemWrite;
                commit    = req && (LATENCY == 1);
            end
            WAIT:    commit = (cnt <= 4'd1);
            default: commit = 1'b0;
        endcase
    end

    assign acc_idx = acc_addr[AW+1:2];
    assign acc_oob = (acc_addr >= BYTE_SIZE);
    assign acc_mis = |acc_addr[1:0];

    // Freeze the pipeline from the request's first cycle until DONE; never
    // while reset is asserted.
    assign mem_stall = !rst && (((state == IDLE) && req) || (state == WAIT));

    assign out1 = OUT1_OK ? mem[OUT1_IDX] : 32'd0;
    assign out2 = OUT2_OK ? mem[OUT2_IDX] : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all sequential state so every
            // register samples pre-edge values regardless of statement order.
            state      <= IDLE;
            cnt        <= 4'd0;
            read_data  <= 32'd0;
            resp_valid <= 1'b0;
            addr_err   <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_rd     <= 1'b0;
            lat_wr     <= 1'b0;
            // NOTE: the array is cleared by reset on purpose: software relies
            // on zeroed memory, so this cannot map onto a plain RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            resp_valid <= 1'b0;
            addr_err   <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (req) begin
                        lat_addr  <= address;
                        lat_wdata <= write_data;
                        lat_rd    <= MemRead;
                        lat_wr    <= MemWrite;
                        cnt       <= CNT_INIT;
                        state     <= (LATENCY > 1) ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        cnt   <= 4'd0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    // Unconditional: a request still held here is not taken
                    // until the following IDLE cycle.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (commit) begin
                resp_valid <= 1'b1;
                addr_err   <= acc_oob | acc_mis;
                if (acc_oob) begin
                    read_data <= 32'd0;
                end else begin
                    if (acc_wr) begin
                        mem[acc_idx] <= acc_wdata;
                    end
                    // A combined read+write returns the pre-write word because
                    // the array update above lands after this edge.
                    if (acc_rd) begin
                        read_data <= mem[acc_idx];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder (DEPTH=256, LATENCY=3). Each request
// pushes its hand-computed response into a queue; an independent monitor
// pops and compares whenever resp_valid is seen. The stimulus side checks
// stall timing, mirror outputs and reset behaviour.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int LAT = 3;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        mem_stall;
    logic        resp_valid;
    logic        addr_err;
    logic [31:0] out1;
    logic [31:0] out2;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    data_mem_responder #(
        .DEPTH    (256),
        .LATENCY  (LAT),
        .OUT1_ADDR(32'd512),
        .OUT2_ADDR(32'd516)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .mem_stall (mem_stall),
        .resp_valid(resp_valid),
        .addr_err  (addr_err),
        .out1      (out1),
        .out2      (out2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: compares every response against the scoreboard, and checks
    // that addr_err stays low whenever no response is presented.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_read_data", read_data, e.rd);
                check("resp_addr_err", {31'd0, addr_err}, {31'd0, e.err});
            end
        end else if (rst === 1'b0) begin
            check("idle_addr_err", {31'd0, addr_err}, 32'd0);
        end
    end

    // Issue one request at the start of a cycle (just after posedge) and
    // follow it through stall, DONE and the following idle cycle.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_rd,
                          input logic exp_err);
        exp_t e;
        e.rd  = exp_rd;
        e.err = exp_err;
        exp_q.push_back(e);
        MemRead    = rd;
        MemWrite   = wr;
        address    = addr;
        write_data = data;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("stall_active", {31'd0, mem_stall}, 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("stall_done", {31'd0, mem_stall}, 32'd0);
        check("valid_done", {31'd0, resp_valid}, 32'd1);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("valid_after", {31'd0, resp_valid}, 32'd0);
        check("read_data_hold", read_data, exp_rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        // Request visible while reset is held: no stall, reset values out.
        MemWrite   = 1'b1;
        address    = 32'd512;
        write_data = 32'hDEADBEEF;
        @(negedge clk);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("rst_out1", out1, 32'd0);
        check("rst_out2", out2, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Accepted in the first cycle after release; mirror updated after.
        do_req(1'b0, 1'b1, 32'd512, 32'hDEADBEEF, 32'd0, 1'b0);
        check("out1_after_write", out1, 32'hDEADBEEF);

        do_req(1'b1, 1'b0, 32'd512, 32'd0, 32'hDEADBEEF, 1'b0);
        // Misaligned read: low bits ignored, word 128 returned, flagged.
        do_req(1'b1, 1'b0, 32'h202, 32'd0, 32'hDEADBEEF, 1'b1);
        // Out-of-range write: suppressed, read_data forced to 0, flagged.
        do_req(1'b0, 1'b1, 32'h400, 32'h1234, 32'd0, 1'b1);
        check("out1_oob_untouched", out1, 32'hDEADBEEF);
        // Word 0 would alias 0x400 if the suppression failed.
        do_req(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);

        // Reset during WAIT aborts the write and produces no response.
        MemWrite   = 1'b1;
        address    = 32'd516;
        write_data = 32'h55;
        @(negedge clk);
        check("abort_stall", {31'd0, mem_stall}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_stall_rst", {31'd0, mem_stall}, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        MemWrite = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_out2", out2, 32'd0);
        check("abort_out1_cleared", out1, 32'd0);
        check("abort_read_data", read_data, 32'd0);

        // Combined read+write returns the pre-write word.
        do_req(1'b0, 1'b1, 32'd516, 32'h11, 32'd0, 1'b0);
        check("out2_first_write", out2, 32'h11);
        do_req(1'b1, 1'b1, 32'd516, 32'hAA, 32'h11, 1'b0);
        check("out2_dual_write", out2, 32'hAA);
        do_req(1'b1, 1'b0, 32'd516, 32'd0, 32'hAA, 1'b0);
        // Misaligned write still lands in word 129, read_data untouched.
        do_req(1'b0, 1'b1, 32'h205, 32'h77, 32'hAA, 1'b1);
        check("out2_misaligned_write", out2, 32'h77);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words in the array (a power of 2).
REQ-002 The module SHALL have parameter LATENCY, default 3, meaning the cycles from request acceptance to response (legal range 1..15).
REQ-003 The module SHALL have parameter OUT1_ADDR, default 512, meaning the byte address mirrored on out1.
REQ-004 The module SHALL have parameter OUT2_ADDR, default 516, meaning the byte address mirrored on out2.
REQ-005 The module SHALL have the port: clk  in  1  single clock, all state updates on the rising edge.
REQ-006 The module SHALL have the port: rst  in  1  reset, synchronous and active-high.
REQ-007 The module SHALL have the port: MemRead  in  1  read request from the MEM stage.
REQ-008 The module SHALL have the port: MemWrite  in  1  write request from the MEM stage.
REQ-009 The module SHALL have the port: address  in  32  byte address, equal to the ALU result.
REQ-010 The module SHALL have the port: write_data  in  32  store data taken from the rt register.
REQ-011 The module SHALL have the port: read_data  out  32  registered load data.
REQ-012 The module SHALL have the port: mem_stall  out  1  pipeline freeze request.
REQ-013 The module SHALL have the port: resp_valid  out  1  one-cycle completion pulse.
REQ-014 The module SHALL have the port: addr_err  out  1  misaligned or out-of-range flag, valid with resp_valid.
REQ-015 The module SHALL have the port: out1  out  32  the word at OUT1_ADDR.
REQ-016 The module SHALL have the port: out2  out  32  the word at OUT2_ADDR.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT and DONE.
REQ-018 In IDLE, a request (MemRead|MemWrite) SHALL be accepted: latch address, write_data and op, and load counter with LATENCY-1.
REQ-019 On acceptance, the FSM SHALL go to WAIT if LATENCY>1 and to DONE otherwise.
REQ-020 In WAIT, the counter SHALL decrement each cycle; when it reaches 0 the FSM SHALL go to DONE.
REQ-021 In DONE, the FSM SHALL go to IDLE unconditionally.
REQ-022 A request still present during DONE SHALL NOT be re-accepted.
REQ-023 mem_stall SHALL equal (IDLE & (MemRead|MemWrite)) | WAIT, combinationally; it SHALL be 0 in DONE.
REQ-024 The array write and the read_data capture SHALL occur on the edge that enters DONE.
REQ-025 resp_valid SHALL be 1 exactly during DONE.
REQ-026 Total latency SHALL be: request first seen at cycle T -> resp_valid at cycle T+LATENCY.
REQ-027 The pipeline SHALL hold its request inputs stable while mem_stall=1; the block SHALL use only the latched copies.
REQ-028 The word index SHALL be address[log2(DEPTH)+1:2].
REQ-029 If address[1:0]!=0, the low bits SHALL be ignored and addr_err=1.
REQ-030 If address >= 4*DEPTH, the access SHALL be suppressed (no write, read_data=0) and addr_err=1.
REQ-031 If MemRead and MemWrite are both 1, the access SHALL be treated as a write, and read_data SHALL return the pre-write contents.
REQ-032 read_data SHALL hold its last value outside DONE.
REQ-033 addr_err SHALL be 0 outside DONE.
REQ-034 On a write, read_data SHALL be unchanged, except for the dual-op case in REQ-031.
REQ-035 out1 and out2 SHALL be combinational from the array and SHALL reflect a write from the cycle after the commit edge.
REQ-036 Back-to-back requests SHALL be spaced by at least LATENCY+1 cycles with no bubble beyond DONE.

Reset
REQ-037 When rst=1 at a clock edge: state=IDLE, counter=0, read_data=0, resp_valid=0, addr_err=0, and all array words SHALL be cleared to 0.
REQ-038 While rst=1, mem_stall SHALL be 0.
REQ-039 A reset mid-operation (WAIT) SHALL abort the access: the pending write is dropped and no resp_valid is produced.
REQ-040 A request present in the first cycle after reset release SHALL be accepted normally.

Verification (LATENCY=3, DEPTH=256)
REQ-041 Write 0xDEADBEEF to address 512 at cycle 0 -> mem_stall=1 in cycles 0-2, resp_valid=1 in cycle 3, out1=0xDEADBEEF from cycle 4.
REQ-042 Read address 512 after REQ-041 -> read_data=0xDEADBEEF with resp_valid, addr_err=0.
REQ-043 Read address 0x202 -> word 128 is returned, addr_err=1.
REQ-044 Write 0x1234 to address 0x400 -> no array change, addr_err=1, read_data=0.
REQ-045 Write 0x55 to address 516, rst=1 in cycle 1 -> no resp_valid, out2 stays 0.
REQ-046 MemRead=MemWrite=1, address 516, data 0xAA, word previously 0x11 -> read_data=0x11, out2=0xAA afterwards.
